// File: rtl/insn_loader_encoder.sv
// RV32I field-to-word encoder feeding a small FIFO that streams words into
// an instruction memory write port at consecutive word addresses.
module insn_loader_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clear_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 fmt_i,
  input  logic [6:0]                 opcode_i,
  input  logic [4:0]                 rd_i,
  input  logic [4:0]                 rs1_i,
  input  logic [4:0]                 rs2_i,
  input  logic [2:0]                 funct3_i,
  input  logic [6:0]                 funct7_i,
  input  logic [31:0]                imm_i,
  output logic                       mem_we_o,
  input  logic                       mem_ready_i,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0]       word_d;
  logic              illegal_d;

  logic [31:0]       fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       last_q, last_d;
  logic              err_q, err_d;

  logic              push, pop;

  always_comb begin
    word_d    = '0;
    illegal_d = 1'b0;
    unique case (fmt_i)
      FMT_R: word_d = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_d = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_d = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_d = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_d = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_d = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                       rd_i, opcode_i};
      default: begin
        word_d    = NOP_WORD;
        illegal_d = 1'b1;
      end
    endcase
  end

  // in_ready looks only at the registered count: a full FIFO refuses a push
  // even when a pop frees a slot on the same edge.
  assign in_ready_o = (count_q != CNT_W'(DEPTH));
  assign mem_we_o   = (count_q != '0);
  assign push       = in_valid_i && in_ready_o && !clear_i;
  assign pop        = mem_we_o && mem_ready_i && !clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    last_d   = last_q;
    err_d    = err_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      addr_d   = BASE_ADDR;
      last_d   = '0;
      err_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (illegal_d) err_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_W'(4);
        last_d   = fifo_q[rd_ptr_q];
      end
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      last_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= word_d;
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = mem_we_o ? fifo_q[rd_ptr_q] : last_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_insn_loader_encoder.sv
// Bench for insn_loader_encoder: directed encodings plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_insn_loader_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam logic [ADDR_W-1:0] BASE = '0;

  logic              clk = 1'b0;
  logic              reset, clear, in_valid, in_ready, mem_we, mem_ready, err;
  logic [2:0]        fmt, funct3;
  logic [6:0]        opcode, funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        count;

  insn_loader_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .reset_i(reset), .clear_i(clear),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .mem_we_o(mem_we), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state
  logic [31:0] mq[$];
  int unsigned m_addr;
  logic        m_err;
  logic [31:0] m_last;
  logic        accepted;
  logic        wrap_seen;

  // observed writes (address, data) taken from the DUT port
  int unsigned obs_addr[$];
  logic [31:0] obs_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int unsigned f, input int unsigned op,
      input int unsigned d, input int unsigned s1, input int unsigned s2,
      input int unsigned f3, input int unsigned f7, input int unsigned im);
    int unsigned base_r;
    base_r = (s2 << 20) + (s1 << 15) + (f3 << 12) + op;
    case (f)
      0: return (f7 << 25) + base_r + (d << 7);
      1: return ((im % 4096) << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
      2: return (((im >> 5) % 128) << 25) + base_r + ((im % 32) << 7);
      3: return (((im >> 12) % 2) << 31) + (((im >> 5) % 64) << 25) + base_r
              + (((im >> 1) % 16) << 8) + (((im >> 11) % 2) << 7);
      4: return (im / 4096) * 4096 + (d << 7) + op;
      5: return (((im >> 20) % 2) << 31) + (((im >> 1) % 1024) << 21)
              + (((im >> 11) % 2) << 20) + (((im >> 12) % 256) << 12) + (d << 7) + op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr = BASE;
    m_err  = 1'b0;
    m_last = '0;
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("mem_we", 32'(mem_we), 32'(mq.size() != 0));
    chk("mem_addr", 32'(mem_addr), m_addr);
    chk("mem_wdata", mem_wdata, (mq.size() != 0) ? mq[0] : m_last);
    chk("err", 32'(err), 32'(m_err));
  endtask

  // Inputs are already driven (we sit at a falling edge); apply one rising edge.
  task automatic cycle();
    logic do_push, do_pop;
    logic [31:0] w;
    do_push = in_valid && (mq.size() < DEPTH) && !clear;
    do_pop  = (mq.size() != 0) && mem_ready && !clear;
    w = ref_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
    if (mem_we && mem_ready && !clear) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
    @(posedge clk);
    if (clear) model_reset();
    else begin
      if (do_pop) begin
        m_last = mq.pop_front();
        if (m_addr + 4 >= (1 << ADDR_W)) wrap_seen = 1'b1;
        m_addr = (m_addr + 4) % (1 << ADDR_W);
      end
      if (do_push) begin
        mq.push_back(w);
        if (fmt > 5) m_err = 1'b1;
      end
    end
    accepted = do_push;
    @(negedge clk);
    check_all();
  endtask

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'd0; imm = im;
  endtask

  task automatic rand_fields();
    fmt = 3'($urandom_range(0, 7)); opcode = 7'($urandom); rd = 5'($urandom);
    rs1 = 5'($urandom); rs2 = 5'($urandom); funct3 = 3'($urandom);
    funct7 = 7'($urandom); imm = $urandom;
  endtask

  task automatic do_clear();
    in_valid = 1'b0; clear = 1'b1; cycle(); clear = 1'b0;
    obs_addr.delete(); obs_data.delete();
  endtask

  logic [31:0] exp_w[5];
  int budget;

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
    rand_fields();
    model_reset();
    wrap_seen = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    chk("rst_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check_all();

    // auipc x2, 0x12345
    mem_ready = 1'b1;
    set_fields(3'd4, 7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
    in_valid = 1'b1; cycle(); in_valid = 1'b0;
    chk("auipc_we", 32'(mem_we), 32'd1);
    chk("auipc_addr", 32'(mem_addr), 32'h0);
    chk("auipc_word", mem_wdata, 32'h1234_5117);
    cycle();
    chk("auipc_hold_last", mem_wdata, 32'h1234_5117);

    // beq x1,x2,-4 then jal x1,2048 back-to-back
    do_clear();
    mem_ready = 1'b1; in_valid = 1'b1;
    set_fields(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
    cycle();
    set_fields(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800);
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("bj_nwrites", obs_addr.size(), 2);
    if (obs_addr.size() == 2) begin
      chk("beq_addr", obs_addr[0], 32'h0);
      chk("beq_word", obs_data[0], 32'hFE20_8EE3);
      chk("jal_addr", obs_addr[1], 32'h4);
      chk("jal_word", obs_data[1], 32'h0010_00EF);
    end

    // backpressure: 5 words against a stalled memory
    do_clear();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_fields(); fmt = 3'($urandom_range(0, 5));
      exp_w[i] = ref_encode(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      in_valid = 1'b1;
      cycle();
      if (i == 3) begin
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_count", 32'(count), 32'd4);
      end
    end
    chk("bp_5th_refused", 32'(accepted), 32'd0);
    chk("bp_head_word", mem_wdata, exp_w[0]);
    chk("bp_head_addr", 32'(mem_addr), 32'h0);
    mem_ready = 1'b1;
    budget = 0;
    while (!accepted && budget < 10) begin cycle(); budget++; end
    chk("bp_5th_accepted", 32'(accepted), 32'd1);
    in_valid = 1'b0;
    budget = 0;
    while (mem_we && budget < 10) begin cycle(); budget++; end
    chk("bp_nwrites", obs_addr.size(), 5);
    for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
      chk("bp_addr", obs_addr[i], 32'(4 * i));
      chk("bp_word", obs_data[i], exp_w[i]);
    end

    // illegal format
    do_clear();
    rand_fields(); fmt = 3'd7; in_valid = 1'b1; mem_ready = 1'b1;
    cycle();
    chk("ill_word", mem_wdata, 32'h0000_0013);
    chk("ill_err", 32'(err), 32'd1);
    rand_fields(); fmt = 3'd0;
    cycle(); in_valid = 1'b0;
    cycle();
    chk("ill_err_sticky", 32'(err), 32'd1);
    do_clear();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_addr", 32'(mem_addr), 32'(BASE));

    // asynchronous reset mid-stream
    mem_ready = 1'b1; in_valid = 1'b1; rand_fields(); cycle();
    mem_ready = 1'b0;
    repeat (3) begin rand_fields(); cycle(); end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    obs_addr.delete(); obs_data.delete();
    rand_fields(); in_valid = 1'b1; mem_ready = 1'b1; cycle();
    in_valid = 1'b0; cycle();
    chk("rst_mid_next_addr", (obs_addr.size() != 0) ? obs_addr[0] : 32'hFFFF_FFFF, 32'(BASE));

    // random traffic, long enough without clear to wrap the address space
    for (int c = 0; c < 900; c++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 99) < 80);
      mem_ready = ($urandom_range(0, 99) < 75);
      cycle();
    end
    chk("addr_wrap_seen", 32'(wrap_seen), 32'd1);

    for (int c = 0; c < 500; c++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 99) < 60);
      mem_ready = ($urandom_range(0, 99) < 50);
      clear     = ($urandom_range(0, 99) < 3);
      cycle();
    end
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/insn_loader_encoder.md
# insn_loader_encoder

Sequential RV32I instruction encoder and instruction-memory loader: the write-side counterpart to the control unit's instruction decoders. It accepts instruction fields (format, opcode, registers, funct, immediate) over a valid/ready handshake. It packs them into 32-bit RV32I words, buffers them in a small FIFO, and streams them into the instruction memory write port at consecutive word addresses. It is used for bootstrapping program memory and for driving decoder/CPU benches with legal encodings.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 10, byte-address width of mem_addr
- BASE_ADDR, 0, first write address (word aligned)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock domain
- clear  in  1  synchronous flush: empty FIFO, addr := BASE_ADDR, err := 0
- in_valid  in  1  field set valid
- in_ready  out  1  FIFO can accept (= !full)
- fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
- opcode  in  7  placed in bits [6:0]
- rd, rs1, rs2  in  5 each  register indices
- funct3  in  3  bits [14:12]
- funct7  in  7  bits [31:25], R only
- imm  in  32  full-width immediate, sliced per format
- mem_we  out  1  write request (= FIFO non-empty)
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  byte address of current write
- mem_wdata  out  32  FIFO head word
- count  out  clog2(DEPTH)+1  FIFO occupancy
- err  out  1  sticky: an illegal fmt was accepted

## Operation
- Encoding, with fields not listed forced to 0:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Immediate bits not used by a format are ignored. There is no range check.
- Illegal fmt (6/7): the word 0x00000013 (addi x0,x0,0) is enqueued and err is set.
- Push occurs on in_valid && in_ready. The encoded word is written to the FIFO tail.
- Pop occurs on mem_we && mem_ready. mem_addr then advances by 4, wrapping mod 2^ADDR_W.
- mem_addr[1:0] is always 00.
- Push and pop may happen in the same cycle. count is then unchanged.
- in_ready depends only on registered count. A push is refused when full even if a pop occurs that cycle.
- clear has priority over push and pop in the same cycle. An accepted-looking push during clear is dropped.

## Timing
- Reset (async) values: FIFO empty, count=0, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0x00000000, err=0.
- Latency is 1 cycle: a push at edge k makes mem_we=1 and mem_wdata valid during cycle k+1.
- mem_we, mem_addr and mem_wdata must stay stable while mem_ready=0. No word is dropped or reordered.
- With mem_ready held at 1, throughput is 1 word per cycle.
- When the FIFO is empty, mem_wdata shows the last popped word (or 0 after reset/clear).
- Reset asserted mid-stream discards all queued words immediately (asynchronously). After release, the first write goes to BASE_ADDR.
- err stays set until reset or clear.

## Test plan
- auipc: fmt=4, opcode=0010111, rd=2, imm=0x12345000, mem_ready=1 -> one cycle later mem_we=1, mem_addr=0x000, mem_wdata=0x12345117.
- Branch/jump encodings, pushed back-to-back:
  - beq x1,x2,-4: fmt=3, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC.
  - jal x1,2048: fmt=5, opcode=1101111, rd=1, imm=0x800.
  - Required: writes 0xFE208EE3 @0x000, then 0x001000EF @0x004, on consecutive cycles.
- Backpressure: mem_ready=0, push 5 words -> in_ready=0 after the 4th and count=4. The 5th word is held off and mem_wdata stays on word 1. Set mem_ready=1 -> words 1-5 appear in order at addresses 0,4,8,C,10.
- Illegal fmt=7 -> 0x00000013 is written and err=1. A following legal push leaves err=1. clear -> err=0, mem_addr=BASE_ADDR.
- Wrap: ADDR_W=4, push 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0.
- Reset mid-stream: 3 words queued, mem_ready=0, assert reset between edges -> mem_we=0, count=0, in_ready=1 immediately. The next push is written at BASE_ADDR.
